// File: rtl/poly_coeff_loader.sv
// poly_coeff_loader
//   Collects two operand polynomials from a serial coefficient stream,
//   reduces every coefficient mod Q and packs them into flat vectors that
//   feed the `a` inputs of the two ntt_flat instances. A completed frame is
//   held stable until downstream accepts it.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_coeff/in_last valid this cycle
//   in_ready   loader can accept a coefficient this cycle
//   in_coeff   raw unsigned coefficient (N bits)
//   in_last    marks the final (2D-th) coefficient of a frame
//   out_valid  a_out/b_out hold a complete frame
//   out_ready  downstream consumes the frame
//   a_out      polynomial A, coefficient k at bits [N*(k+1)-1 : N*k]
//   b_out      polynomial B, same packing as a_out
//   frame_err  one-cycle pulse on an in_last framing violation
module poly_coeff_loader #(
  parameter int N = 17,
  parameter int D = 16,
  parameter int Q = 65537
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_coeff,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*D-1:0] a_out,
  output logic [N*D-1:0] b_out,
  output logic           frame_err
);

  localparam int CW = $clog2(2 * D);
  localparam int SW = $clog2(D);
  localparam logic [CW-1:0] LAST_A = CW'(D - 1);
  localparam logic [CW-1:0] LAST_B = CW'(2 * D - 1);
  localparam logic [N:0]    Q_EXT  = (N + 1)'(Q);
  localparam logic [N-1:0]  Q_LO   = N'(Q);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic          early_last;
  logic          missing_last;
  logic [N-1:0]  reduced;
  int            slot_base;

  assign in_ready  = (state != FULL);
  assign out_valid = (state == FULL);
  assign accept    = in_valid && in_ready;

  // Because 2^N <= 2Q, one conditional subtract fully reduces the input.
  // The subtraction wraps in N bits, which is exact whenever in_coeff >= Q.
  assign reduced = ({1'b0, in_coeff} >= Q_EXT) ? (in_coeff - Q_LO) : in_coeff;

  // The low counter bits address a slot in either polynomial; the MSB
  // chooses A or B since D is a power of two.
  assign slot_base = int'(cnt[SW-1:0]) * N;

  // in_last before the final beat aborts the frame; a final beat without
  // in_last still completes the frame but is flagged.
  assign early_last   = accept && in_last && (cnt != LAST_B);
  assign missing_last = accept && !in_last && (cnt == LAST_B);

  // State register, beat counter and framing-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_A;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      frame_err <= early_last || missing_last;
    end
  end

  // Packed coefficient storage; only accepted beats ever write it, so a
  // frame in FULL is naturally held until it is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else if (accept) begin
      if (!cnt[CW-1]) begin
        a_out[slot_base +: N] <= reduced;
      end else begin
        b_out[slot_base +: N] <= reduced;
      end
    end
  end

  // Next-state and counter logic. An early in_last sends the loader back to
  // LOAD_A with the counter cleared, leaving stale slots to be overwritten.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      LOAD_A: begin
        if (accept) begin
          if (in_last) begin
            cnt_next = '0;
          end else begin
            cnt_next = cnt + 1'b1;
            if (cnt == LAST_A) begin
              state_next = LOAD_B;
            end
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (cnt == LAST_B) begin
            cnt_next   = '0;
            state_next = FULL;
          end else if (in_last) begin
            cnt_next   = '0;
            state_next = LOAD_A;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_next = LOAD_A;
        end
      end
      default: begin
        state_next = LOAD_A;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_poly_coeff_loader.sv
// tb_poly_coeff_loader
//   Directed bench for poly_coeff_loader: reduction table, basic frame,
//   backpressure hold, input gaps, early/missing in_last and async reset.
module tb_poly_coeff_loader;

  localparam int N = 17;
  localparam int D = 16;
  localparam int Q = 65537;
  localparam int W = N * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_coeff;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         frame_err;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] frame_vals [2*D];
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;

  typedef struct {
    logic [N-1:0] coeff;
    logic [N-1:0] expected;
  } red_vec_t;

  red_vec_t red_table [8];

  poly_coeff_loader #(.N(N), .D(D), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coeff  (in_coeff),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] modelReduce(input logic [N-1:0] x);
    if (int'(x) >= Q) return N'(int'(x) - Q);
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Drives one beat and waits (bounded) for the handshake edge.
  task automatic applyStimulus(input logic [N-1:0] c, input logic last);
    int   budget;
    logic rdy;
    budget   = 50;
    in_valid = 1'b1;
    in_coeff = c;
    in_last  = last;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end while (!rdy && budget > 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic modelWrite(input int idx, input logic [N-1:0] v);
    if (idx < D) exp_a[idx*N +: N] = modelReduce(v);
    else         exp_b[(idx-D)*N +: N] = modelReduce(v);
  endtask

  task automatic sendFrame(input int last_at, input bit gaps, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      applyStimulus(frame_vals[i], i == last_at);
      modelWrite(i, frame_vals[i]);
    end
  endtask

  task automatic checkFrameDone(input string name, input logic want_err);
    checkOutput({name, " out_valid"}, out_valid, 1);
    checkOutput({name, " frame_err"}, frame_err, want_err);
    checkOutput({name, " in_ready"}, in_ready, 0);
    checkOutput({name, " a_out"}, a_out, exp_a);
    checkOutput({name, " b_out"}, b_out, exp_b);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    red_table[0] = '{coeff: 17'd65536,  expected: 17'd65536};
    red_table[1] = '{coeff: 17'd65537,  expected: 17'd0};
    red_table[2] = '{coeff: 17'd131071, expected: 17'd65534};
    red_table[3] = '{coeff: 17'd0,      expected: 17'd0};
    red_table[4] = '{coeff: 17'd1,      expected: 17'd1};
    red_table[5] = '{coeff: 17'd65535,  expected: 17'd65535};
    red_table[6] = '{coeff: 17'd65538,  expected: 17'd1};
    red_table[7] = '{coeff: 17'd100000, expected: 17'd34463};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_coeff  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    exp_a     = '0;
    exp_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset a_out", a_out, 0);
    checkOutput("reset b_out", b_out, 0);

    $display("[TB] basic frame 1..32");
    for (int i = 0; i < 2*D; i++) frame_vals[i] = N'(i + 1);
    sendFrame(2*D - 1, 1'b0, 2*D);
    checkFrameDone("basic", 1'b0);
    checkOutput("basic a_out[0]", a_out[N-1:0], 1);
    checkOutput("basic b_out[15]", b_out[15*N +: N], 32);
    stepCycle();
    checkOutput("basic released out_valid", out_valid, 0);
    checkOutput("basic released in_ready", in_ready, 1);

    $display("[TB] reduction table and hold");
    out_ready = 1'b0;
    for (int i = 0; i < 2*D; i++)
      frame_vals[i] = (i < 8) ? red_table[i].coeff : N'(i * 4099);
    sendFrame(2*D - 1, 1'b0, 2*D);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("reduce[%0d]", i), a_out[i*N +: N], red_table[i].expected);
    checkFrameDone("table", 1'b0);
    in_valid = 1'b1;
    in_coeff = 17'd12345;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("hold%0d out_valid", c), out_valid, 1);
      checkOutput($sformatf("hold%0d in_ready", c), in_ready, 0);
      checkOutput($sformatf("hold%0d a_out", c), a_out, exp_a);
      checkOutput($sformatf("hold%0d b_out", c), b_out, exp_b);
      stepCycle();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    stepCycle();
    checkOutput("hold released out_valid", out_valid, 0);
    checkOutput("hold released in_ready", in_ready, 1);

    $display("[TB] frame with input gaps");
    for (int i = 0; i < 2*D; i++) frame_vals[i] = N'(i + 1);
    sendFrame(2*D - 1, 1'b1, 2*D);
    checkFrameDone("gaps", 1'b0);
    stepCycle();

    $display("[TB] early in_last at beat 10");
    for (int i = 0; i < 2*D; i++) frame_vals[i] = N'(500 + i);
    sendFrame(9, 1'b0, 10);
    checkOutput("early frame_err", frame_err, 1);
    checkOutput("early out_valid", out_valid, 0);
    checkOutput("early in_ready", in_ready, 1);
    checkOutput("early a_out", a_out, exp_a);
    stepCycle();
    checkOutput("early frame_err drop", frame_err, 0);
    checkOutput("early out_valid stays", out_valid, 0);
    for (int i = 0; i < 2*D; i++) frame_vals[i] = N'(7);
    sendFrame(2*D - 1, 1'b0, 2*D);
    checkFrameDone("sevens", 1'b0);
    checkOutput("sevens a_out[9]", a_out[9*N +: N], 7);
    stepCycle();

    $display("[TB] missing in_last");
    for (int i = 0; i < 2*D; i++) frame_vals[i] = N'(1000 + i * 37);
    sendFrame(-1, 1'b0, 2*D);
    checkFrameDone("missing", 1'b1);
    stepCycle();
    checkOutput("missing frame_err drop", frame_err, 0);

    $display("[TB] async reset mid-frame");
    for (int i = 0; i < 2*D; i++) frame_vals[i] = N'(300 + i);
    sendFrame(-1, 1'b0, 20);
    #2;
    rst = 1'b1;
    #1;
    exp_a = '0;
    exp_b = '0;
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset frame_err", frame_err, 0);
    checkOutput("midreset a_out", a_out, exp_a);
    checkOutput("midreset b_out", b_out, exp_b);
    #1;
    rst = 1'b0;
    stepCycle();
    for (int i = 0; i < 2*D; i++) frame_vals[i] = N'(900 + i);
    sendFrame(2*D - 1, 1'b0, 2*D);
    checkFrameDone("after reset", 1'b0);
    checkOutput("after reset a_out[0]", a_out[N-1:0], 900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
